// File: rtl/ripple_count_monitor_pkg.sv
// Shared constants and compare-FSM encoding for the ripple count monitor.
package ripple_count_monitor_pkg;

    localparam int CW_DEF     = 4;
    localparam int WRAPW_DEF  = 4;
    localparam int STABLE_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_HIT   = 2'd2
    } cmp_state_e;

endpackage

// File: rtl/ripple_count_monitor_stable_sampler.sv
// History shift register over the raw rippled count. A value is offered for
// acceptance only once every history slot holds it and it differs from the
// currently published count, so ripple transients shorter than DEPTH samples
// never get through.
module stable_sampler #(
    parameter int W     = 4,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] sample_i,
    input  logic [W-1:0] ref_i,
    output logic         accept_o,
    output logic [W-1:0] value_o
);

    logic [W-1:0] hist_q [DEPTH];
    logic         all_eq;

    // Shift a new raw sample in on every clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                hist_q[i] <= '0;
            end
        end else begin
            hist_q[0] <= sample_i;
            for (int i = 1; i < DEPTH; i++) begin
                hist_q[i] <= hist_q[i-1];
            end
        end
    end

    // All history slots must agree with the newest one.
    always_comb begin
        all_eq = 1'b1;
        for (int i = 1; i < DEPTH; i++) begin
            if (hist_q[i] != hist_q[0]) begin
                all_eq = 1'b0;
            end
        end
    end

    assign value_o  = hist_q[0];
    assign accept_o = all_eq && (hist_q[0] != ref_i);

endmodule

// File: rtl/ripple_count_monitor.sv
// Clean-count monitor for an asynchronous ripple up counter: publishes the
// debounced count, flags wraps and discontinuities, keeps a saturating wrap
// counter with sticky overflow, and runs a one-shot armed compare.
module ripple_count_monitor
    import ripple_count_monitor_pkg::*;
#(
    parameter int CW     = CW_DEF,
    parameter int WRAPW  = WRAPW_DEF,
    parameter int STABLE = STABLE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CW-1:0]    count_in,
    input  logic             arm,
    input  logic             clear,
    input  logic [CW-1:0]    match_val,
    output logic [CW-1:0]    count_q,
    output logic             upd_pulse,
    output logic             wrap_pulse,
    output logic             disc_pulse,
    output logic [WRAPW-1:0] wrap_cnt,
    output logic             overflow,
    output logic             armed,
    output logic             match_pulse
);

    localparam logic [CW-1:0]    CNT_MAX  = {CW{1'b1}};
    localparam logic [WRAPW-1:0] WRAP_MAX = {WRAPW{1'b1}};

    logic             accept;
    logic [CW-1:0]    new_val;

    logic [CW-1:0]    cnt_q, cnt_d;
    logic             upd_q, wrap_q, disc_q;
    logic             is_wrap, is_disc;
    logic [WRAPW-1:0] wrap_cnt_q, wrap_cnt_d;
    logic             ovf_q, ovf_d;

    cmp_state_e       state_q, state_d;
    logic [CW-1:0]    match_reg_q, match_reg_d;
    logic             match_q, match_d;

    stable_sampler #(
        .W     (CW),
        .DEPTH (STABLE)
    ) u_sampler (
        .clk      (clk),
        .rst      (rst),
        .sample_i (count_in),
        .ref_i    (cnt_q),
        .accept_o (accept),
        .value_o  (new_val)
    );

    // Classify an accepted update and maintain the wrap counter; clear wins.
    always_comb begin
        cnt_d      = cnt_q;
        is_wrap    = 1'b0;
        is_disc    = 1'b0;
        wrap_cnt_d = wrap_cnt_q;
        ovf_d      = ovf_q;
        if (accept) begin
            cnt_d   = new_val;
            is_wrap = (cnt_q == CNT_MAX) && (new_val == '0);
            is_disc = !is_wrap && (new_val < cnt_q);
        end
        if (clear) begin
            wrap_cnt_d = '0;
            ovf_d      = 1'b0;
        end else if (is_wrap) begin
            if (wrap_cnt_q == WRAP_MAX) begin
                ovf_d = 1'b1;
            end else begin
                wrap_cnt_d = wrap_cnt_q + 1'b1;
            end
        end
    end

    // Compare FSM: only a fresh accepted update can hit; clear forces IDLE.
    always_comb begin
        state_d     = state_q;
        match_reg_d = match_reg_q;
        match_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    state_d     = ST_ARMED;
                    match_reg_d = match_val;
                end
            end
            ST_ARMED: begin
                if (accept && (new_val == match_reg_q)) begin
                    state_d = ST_HIT;
                    match_d = 1'b1;
                end
            end
            ST_HIT: begin
                if (arm) begin
                    state_d     = ST_ARMED;
                    match_reg_d = match_val;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (clear) begin
            state_d = ST_IDLE;
            match_d = 1'b0;
        end
    end

    // Register published count, pulses, wrap bookkeeping and FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            upd_q       <= 1'b0;
            wrap_q      <= 1'b0;
            disc_q      <= 1'b0;
            wrap_cnt_q  <= '0;
            ovf_q       <= 1'b0;
            state_q     <= ST_IDLE;
            match_reg_q <= '0;
            match_q     <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            upd_q       <= accept;
            wrap_q      <= is_wrap;
            disc_q      <= is_disc;
            wrap_cnt_q  <= wrap_cnt_d;
            ovf_q       <= ovf_d;
            state_q     <= state_d;
            match_reg_q <= match_reg_d;
            match_q     <= match_d;
        end
    end

    assign count_q     = cnt_q;
    assign upd_pulse   = upd_q;
    assign wrap_pulse  = wrap_q;
    assign disc_pulse  = disc_q;
    assign wrap_cnt    = wrap_cnt_q;
    assign overflow    = ovf_q;
    assign armed       = (state_q == ST_ARMED);
    assign match_pulse = match_q;

endmodule

// File: tb/tb_ripple_count_monitor.sv
// Bench for ripple_count_monitor: directed scenarios plus random stimulus,
// every cycle checked against a behavioural model of the monitor.
module tb_ripple_count_monitor;

    localparam int CW     = 4;
    localparam int WRAPW  = 4;
    localparam int STABLE = 2;
    localparam int CMAX   = 15;
    localparam int WMAX   = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] count_in;
    logic          arm;
    logic          clear;
    logic [CW-1:0] match_val;
    logic [CW-1:0] count_q;
    logic          upd_pulse, wrap_pulse, disc_pulse;
    logic [WRAPW-1:0] wrap_cnt;
    logic          overflow, armed, match_pulse;

    int checks   = 0;
    int failures = 0;

    // pulse tallies and watch flags
    int upd_seen = 0, wrap_seen = 0, disc_seen = 0, match_seen = 0;
    int saw_four = 0, pulse_after = 0;
    bit watch_four = 0, watch_post = 0;

    // behavioural model state
    int m_hist[STABLE];
    int m_count, m_wraps, m_mode, m_target;
    bit m_ovf;
    bit e_upd, e_wrap, e_disc, e_match;
    bit m_acc;
    int m_new, m_old;

    ripple_count_monitor #(
        .CW     (CW),
        .WRAPW  (WRAPW),
        .STABLE (STABLE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .count_in    (count_in),
        .arm         (arm),
        .clear       (clear),
        .match_val   (match_val),
        .count_q     (count_q),
        .upd_pulse   (upd_pulse),
        .wrap_pulse  (wrap_pulse),
        .disc_pulse  (disc_pulse),
        .wrap_cnt    (wrap_cnt),
        .overflow    (overflow),
        .armed       (armed),
        .match_pulse (match_pulse)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: m_mode 0 = idle, 1 = waiting for target, 2 = just matched.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STABLE; i++) m_hist[i] = 0;
            m_count = 0; m_wraps = 0; m_ovf = 0; m_mode = 0; m_target = 0;
            e_upd = 0; e_wrap = 0; e_disc = 0; e_match = 0;
        end else begin
            m_new = m_hist[0];
            m_acc = (m_new != m_count);
            for (int i = 1; i < STABLE; i++) if (m_hist[i] != m_new) m_acc = 0;
            m_old  = m_count;
            e_upd  = m_acc;
            e_wrap = m_acc && (m_old == CMAX) && (m_new == 0);
            e_disc = m_acc && !e_wrap && (m_new < m_old);
            if (m_acc) m_count = m_new;
            for (int i = STABLE - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = int'(count_in);
            if (clear) begin
                m_wraps = 0; m_ovf = 0;
            end else if (e_wrap) begin
                if (m_wraps == WMAX) m_ovf = 1;
                else m_wraps++;
            end
            e_match = 0;
            if (clear) begin
                m_mode = 0;
            end else if (m_mode == 1) begin
                if (m_acc && m_new == m_target) begin
                    m_mode = 2; e_match = 1;
                end
            end else if (arm) begin
                m_mode = 1; m_target = int'(match_val);
            end else begin
                m_mode = 0;
            end
        end
    end

    // Scoreboard compare away from the active edge, every cycle.
    always @(negedge clk) begin
        check("count_q",     count_q,     m_count);
        check("upd_pulse",   upd_pulse,   e_upd);
        check("wrap_pulse",  wrap_pulse,  e_wrap);
        check("disc_pulse",  disc_pulse,  e_disc);
        check("wrap_cnt",    wrap_cnt,    m_wraps);
        check("overflow",    overflow,    m_ovf);
        check("armed",       armed,       m_mode == 1);
        check("match_pulse", match_pulse, e_match);
        if (upd_pulse)   upd_seen++;
        if (wrap_pulse)  wrap_seen++;
        if (disc_pulse)  disc_seen++;
        if (match_pulse) match_seen++;
        if (watch_four && count_q == 4) saw_four++;
        if (watch_post && (upd_pulse || wrap_pulse || disc_pulse || match_pulse)) pulse_after++;
    end

    // driver tasks
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic hold(input int v, input int n);
        count_in = CW'(v);
        tick(n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b_upd, b_wrap, b_disc, b_match, v, n;
        rst = 1'b1; count_in = '0; arm = 1'b0; clear = 1'b0; match_val = '0;
        #10 rst = 1'b0;
        tick(1);
        check("reset_count_q",  count_q,  0);
        check("reset_wrap_cnt", wrap_cnt, 0);
        check("reset_armed",    armed,    0);

        // 1: ramp 0..15, one step per 2 clocks
        b_upd = upd_seen; b_disc = disc_seen;
        for (int s = 1; s <= 15; s++) begin
            count_in = CW'(s);
            tick(1);
            if (s == 2) check("lag_second", count_q, 1);
            tick(1);
            if (s == 1) check("lag_first", count_q, 0);
        end
        tick(3);
        check("ramp_upd_count",  upd_seen - b_upd, 15);
        check("ramp_disc_count", disc_seen - b_disc, 0);
        check("ramp_final",      count_q, 15);

        // 2: wraps, saturation, clear
        hold(0, 4);
        check("first_wrap_cnt", wrap_cnt, 1);
        for (int w = 0; w < 15; w++) begin
            hold(15, 4);
            hold(0, 4);
        end
        check("sat_wrap_cnt", wrap_cnt, 15);
        check("sat_overflow", overflow, 1);
        clear = 1'b1; tick(1); clear = 1'b0;
        check("clear_wrap_cnt", wrap_cnt, 0);
        check("clear_overflow", overflow, 0);
        hold(15, 4);
        b_wrap = wrap_seen;
        count_in = '0;
        tick(2);
        clear = 1'b1; tick(1); clear = 1'b0;
        tick(1);
        check("clear_wrap_same_pulse", wrap_seen - b_wrap, 1);
        check("clear_wrap_same_cnt",   wrap_cnt, 0);

        // 3: one-sample glitch is rejected
        hold(5, 4);
        watch_four = 1;
        hold(4, 1);
        hold(6, 4);
        watch_four = 0;
        check("glitch_seen", saw_four, 0);
        check("glitch_final", count_q, 6);

        // 4: upstream reset mid-count
        hold(7, 4);
        b_wrap = wrap_seen; b_disc = disc_seen;
        hold(0, 4);
        check("disc_count", disc_seen - b_disc, 1);
        check("disc_nowrap", wrap_seen - b_wrap, 0);
        check("disc_wrap_cnt", wrap_cnt, 0);

        // 5: armed compare
        b_match = match_seen;
        arm = 1'b1; match_val = 4'd9; tick(1); arm = 1'b0;
        check("armed_set", armed, 1);
        for (int s = 1; s <= 15; s++) hold(s, 2);
        tick(3);
        check("match_once", match_seen - b_match, 1);
        check("armed_after", armed, 0);
        arm = 1'b1; clear = 1'b1; tick(1); arm = 1'b0; clear = 1'b0;
        check("arm_clear", armed, 0);

        // random phase
        for (int r = 0; r < 700; r++) begin
            v = $urandom_range(0, 15);
            if ($urandom_range(0, 3) == 0) v = (count_in == 4'd15) ? 0 : 15;
            n = $urandom_range(1, 4);
            count_in = CW'(v);
            for (int k = 0; k < n; k++) begin
                arm = ($urandom_range(0, 7) == 0);
                match_val = CW'($urandom_range(0, 15));
                clear = ($urandom_range(0, 31) == 0);
                tick(1);
            end
        end
        arm = 1'b0; clear = 1'b0;

        // 6: async reset while busy
        hold(0, 4);
        clear = 1'b1; tick(1); clear = 1'b0;
        for (int w = 0; w < 3; w++) begin
            hold(15, 4);
            hold(0, 4);
        end
        hold(12, 4);
        arm = 1'b1; match_val = 4'd3; tick(1); arm = 1'b0;
        check("pre_rst_count", count_q, 12);
        check("pre_rst_wraps", wrap_cnt, 3);
        check("pre_rst_armed", armed, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_now_outputs",
              {count_q, upd_pulse, wrap_pulse, disc_pulse, wrap_cnt, overflow, armed, match_pulse}, 0);
        count_in = '0;
        tick(1);
        rst = 1'b0;
        watch_post = 1;
        tick(6);
        watch_post = 0;
        check("post_rst_pulses", pulse_after, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
